// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register merged with the decode-stage hazard unit.
//   Every edge it captures the decoded operands/control from ID. When the
//   instruction in ID depends on a load in EX, or a beq in ID depends on a
//   result that is not yet available, it holds PC and IF/ID and loads a bubble
//   into EX. It also resolves beq in ID and requests the IF flush.
//
// Ports
//   clk_i, rst_n_i            clock (rising edge), async active-low reset
//   id_*                      register fields, operands and control from ID
//   id_branch_i, id_eq_i      beq in ID and equal-compare result
//   pc_write_o, if_id_write_o PC / IF-ID load enables (low while stalled)
//   if_flush_o                clear IF/ID on the next edge (taken branch)
//   branch_taken_o            select branch target into PC
//   ex_*                      registered control, operands and register fields
//   stall_cnt_o               saturating count of stalled cycles
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [4:0]        id_rs_addr_i,
  input  logic [4:0]        id_rt_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic              id_branch_i,
  input  logic              id_eq_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_flush_o,
  output logic              branch_taken_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_alu_src_o,
  output logic              ex_reg_dst_o,
  output logic [1:0]        ex_alu_op_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs_addr_o,
  output logic [4:0]        ex_rt_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [4:0] ex_dest;
  logic [4:0] mem_dest_q;
  logic       mem_load_q;
  logic       haz_load_use;
  logic       haz_br_ex;
  logic       haz_br_mem;
  logic       stall;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic src_match(input logic [4:0] d,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (d != 5'd0) && ((d == rs) || (d == rt));
  endfunction

  assign ex_dest = ex_reg_dst_o ? ex_rd_addr_o : ex_rt_addr_o;

  // beq compares in ID, so it needs both an ALU result from EX and load data
  // from MEM to have reached the register file; a plain ALU consumer only
  // waits on a load in EX (forwarding covers the rest).
  assign haz_load_use = ex_mem_read_o && src_match(ex_dest, id_rs_addr_i, id_rt_addr_i);
  assign haz_br_ex    = id_branch_i && ex_reg_write_o &&
                        src_match(ex_dest, id_rs_addr_i, id_rt_addr_i);
  assign haz_br_mem   = id_branch_i && mem_load_q &&
                        src_match(mem_dest_q, id_rs_addr_i, id_rt_addr_i);
  assign stall        = haz_load_use || haz_br_ex || haz_br_mem;

  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    branch_taken_o = 1'b0;
    if_flush_o     = 1'b0;
    if (stall) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else begin
      branch_taken_o = id_branch_i && id_eq_i;
      if_flush_o     = id_branch_i && id_eq_i;
    end
  end

  // EX never stalls: every edge loads either the ID instruction or a bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_reg_write_o  <= 1'b0;
      ex_mem_to_reg_o <= 1'b0;
      ex_mem_read_o   <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_alu_src_o    <= 1'b0;
      ex_reg_dst_o    <= 1'b0;
      ex_alu_op_o     <= 2'b00;
      ex_rs_data_o    <= '0;
      ex_rt_data_o    <= '0;
      ex_imm_o        <= '0;
      ex_rs_addr_o    <= 5'd0;
      ex_rt_addr_o    <= 5'd0;
      ex_rd_addr_o    <= 5'd0;
    end else if (stall) begin
      ex_reg_write_o  <= 1'b0;
      ex_mem_to_reg_o <= 1'b0;
      ex_mem_read_o   <= 1'b0;
      ex_mem_write_o  <= 1'b0;
      ex_alu_src_o    <= 1'b0;
      ex_reg_dst_o    <= 1'b0;
      ex_alu_op_o     <= 2'b00;
      ex_rs_data_o    <= '0;
      ex_rt_data_o    <= '0;
      ex_imm_o        <= '0;
      ex_rs_addr_o    <= 5'd0;
      ex_rt_addr_o    <= 5'd0;
      ex_rd_addr_o    <= 5'd0;
    end else begin
      ex_reg_write_o  <= id_reg_write_i;
      ex_mem_to_reg_o <= id_mem_to_reg_i;
      ex_mem_read_o   <= id_mem_read_i;
      ex_mem_write_o  <= id_mem_write_i;
      ex_alu_src_o    <= id_alu_src_i;
      ex_reg_dst_o    <= id_reg_dst_i;
      ex_alu_op_o     <= id_alu_op_i;
      ex_rs_data_o    <= id_rs_data_i;
      ex_rt_data_o    <= id_rt_data_i;
      ex_imm_o        <= id_imm_i;
      ex_rs_addr_o    <= id_rs_addr_i;
      ex_rt_addr_o    <= id_rt_addr_i;
      ex_rd_addr_o    <= id_rd_addr_i;
    end
  end

  // Shadow of the MEM stage: only what the branch-after-load check needs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_dest_q <= 5'd0;
      mem_load_q <= 1'b0;
    end else begin
      mem_dest_q <= ex_dest;
      mem_load_q <= ex_mem_read_o && ex_reg_write_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;
  localparam int EX_W   = 8 + 3 * DATA_W + 15;

  typedef struct packed {
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              reg_dst;
    logic [1:0]        alu_op;
    logic              branch;
    logic              eq;
  } instr_t;

  typedef struct {
    string            name;
    logic [3:0]       obs_ctl;
    logic [3:0]       exp_ctl;
    logic [EX_W-1:0]  exp_ex;
    logic [CNT_W-1:0] exp_cnt;
  } sb_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic [4:0]        id_rs_addr_i = '0, id_rt_addr_i = '0, id_rd_addr_i = '0;
  logic [DATA_W-1:0] id_rs_data_i = '0, id_rt_data_i = '0, id_imm_i = '0;
  logic              id_reg_write_i = 0, id_mem_to_reg_i = 0, id_mem_read_i = 0;
  logic              id_mem_write_i = 0, id_alu_src_i = 0, id_reg_dst_i = 0;
  logic [1:0]        id_alu_op_i = '0;
  logic              id_branch_i = 0, id_eq_i = 0;
  logic              pc_write_o, if_id_write_o, if_flush_o, branch_taken_o;
  logic              ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o;
  logic              ex_mem_write_o, ex_alu_src_o, ex_reg_dst_o;
  logic [1:0]        ex_alu_op_o;
  logic [DATA_W-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]        ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  sb_t sb_q[$];

  logic [EX_W-1:0] ex_act;
  logic [3:0]      ctl_act;
  assign ex_act  = {ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o,
                    ex_alu_src_o, ex_reg_dst_o, ex_alu_op_o, ex_rs_data_o, ex_rt_data_o,
                    ex_imm_o, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o};
  assign ctl_act = {pc_write_o, if_id_write_o, branch_taken_o, if_flush_o};

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_alu_src_i(id_alu_src_i), .id_reg_dst_i(id_reg_dst_i), .id_alu_op_i(id_alu_op_i),
    .id_branch_i(id_branch_i), .id_eq_i(id_eq_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_flush_o(if_flush_o),
    .branch_taken_o(branch_taken_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic instr_t mk_nop();
    instr_t i;
    i = '0;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
    instr_t i;
    i = '0;
    i.rs = rs; i.rt = rt;
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.reg_write = 1; i.mem_to_reg = 1; i.mem_read = 1; i.alu_src = 1;
    return i;
  endfunction

  function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt);
    instr_t i;
    i = '0;
    i.rs = rs; i.rt = rt; i.rd = rd;
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.reg_write = 1; i.reg_dst = 1; i.alu_op = 2'b10;
    return i;
  endfunction

  function automatic instr_t mk_beq(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic eq);
    instr_t i;
    i = '0;
    i.rs = rs; i.rt = rt;
    i.rs_data = $urandom; i.rt_data = $urandom; i.imm = $urandom;
    i.alu_op = 2'b01; i.branch = 1; i.eq = eq;
    return i;
  endfunction

  function automatic logic [EX_W-1:0] ex_of(input instr_t i);
    return {i.reg_write, i.mem_to_reg, i.mem_read, i.mem_write, i.alu_src, i.reg_dst,
            i.alu_op, i.rs_data, i.rt_data, i.imm, i.rs, i.rt, i.rd};
  endfunction

  task automatic apply(input instr_t i);
    id_rs_addr_i = i.rs; id_rt_addr_i = i.rt; id_rd_addr_i = i.rd;
    id_rs_data_i = i.rs_data; id_rt_data_i = i.rt_data; id_imm_i = i.imm;
    id_reg_write_i = i.reg_write; id_mem_to_reg_i = i.mem_to_reg;
    id_mem_read_i = i.mem_read; id_mem_write_i = i.mem_write;
    id_alu_src_i = i.alu_src; id_reg_dst_i = i.reg_dst; id_alu_op_i = i.alu_op;
    id_branch_i = i.branch; id_eq_i = i.eq;
  endtask

  // Present one instruction in ID for one cycle. s = stall expected this
  // cycle, t = branch taken/flush expected. The expected EX contents after
  // the edge are queued for the scoreboard.
  task automatic drive(input string name, input instr_t ins, input logic s, input logic t);
    sb_t it;
    @(negedge clk_i);
    apply(ins);
    #1;
    it.name    = name;
    it.obs_ctl = ctl_act;
    it.exp_ctl = {~s, ~s, t, t};
    it.exp_ex  = s ? '0 : ex_of(ins);
    if (s && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    it.exp_cnt = exp_cnt;
    sb_q.push_back(it);
  endtask

  always begin : scoreboard
    sb_t it;
    @(posedge clk_i);
    if (sb_q.size() != 0) begin
      it = sb_q.pop_front();
      #1;
      checks++;
      if (it.obs_ctl !== it.exp_ctl) begin
        errors++;
        $display("FAIL %s ctl{pc_wr,ifid_wr,taken,flush}: got %b want %b",
                 it.name, it.obs_ctl, it.exp_ctl);
      end
      checks++;
      if (ex_act !== it.exp_ex) begin
        errors++;
        $display("FAIL %s ex_regs: got %h want %h", it.name, ex_act, it.exp_ex);
      end
      checks++;
      if (stall_cnt_o !== it.exp_cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d want %0d", it.name, stall_cnt_o, it.exp_cnt);
      end
    end
  end

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    instr_t b;
    b = mk_beq(5'd1, 5'd2, 1'b1);
    rst_n_i = 0;
    apply(b);
    #12;
    checks++;
    if (ex_act !== '0) begin
      errors++;
      $display("FAIL reset ex_regs: got %h want 0", ex_act);
    end
    checks++;
    if (stall_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset stall_cnt: got %0d want 0", stall_cnt_o);
    end
    checks++;
    if (ctl_act !== 4'b1111) begin
      errors++;
      $display("FAIL reset ctl: got %b want 1111", ctl_act);
    end
    @(negedge clk_i);
    apply(mk_nop());
    rst_n_i = 1;
    exp_cnt = '0;
  endtask

  task automatic test_load_use();
    instr_t a;
    a = mk_add(5'd3, 5'd2, 5'd4);
    drive("lu_nop", mk_nop(), 0, 0);
    drive("lu_lw", mk_lw(5'd2, 5'd1), 0, 0);
    drive("lu_add_stall", a, 1, 0);
    drive("lu_add_issue", a, 0, 0);
    settle();
  endtask

  task automatic test_branch_alu();
    instr_t b;
    b = mk_beq(5'd5, 5'd0, 1'b1);
    drive("ba_add", mk_add(5'd5, 5'd6, 5'd7), 0, 0);
    drive("ba_beq_stall", b, 1, 0);
    drive("ba_beq_taken", b, 0, 1);
    drive("ba_after", mk_nop(), 0, 0);
    settle();
  endtask

  task automatic test_branch_load();
    instr_t b;
    b = mk_beq(5'd8, 5'd9, 1'b1);
    drive("bl_lw", mk_lw(5'd8, 5'd1), 0, 0);
    drive("bl_beq_stall_ex", b, 1, 0);
    drive("bl_beq_stall_mem", b, 1, 0);
    drive("bl_beq_taken", b, 0, 1);
    drive("bl_after", mk_nop(), 0, 0);
    settle();
  endtask

  task automatic test_zero_reg();
    drive("z_lw0", mk_lw(5'd0, 5'd1), 0, 0);
    drive("z_add", mk_add(5'd3, 5'd0, 5'd0), 0, 0);
    drive("z_beq00", mk_beq(5'd0, 5'd0, 1'b1), 0, 1);
    drive("z_after", mk_nop(), 0, 0);
    settle();
  endtask

  task automatic test_branch_no_hazard();
    drive("nh_beq_ne", mk_beq(5'd10, 5'd11, 1'b0), 0, 0);
    drive("nh_beq_eq", mk_beq(5'd10, 5'd11, 1'b1), 0, 1);
    drive("nh_after", mk_nop(), 0, 0);
    settle();
  endtask

  task automatic test_saturation();
    instr_t a;
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      a = mk_add(5'd3, 5'd2, 5'd4);
      drive("sat_lw", mk_lw(5'd2, 5'd1), 0, 0);
      drive("sat_stall", a, 1, 0);
      drive("sat_issue", a, 0, 0);
    end
    settle();
    checks++;
    if (stall_cnt_o !== {CNT_W{1'b1}}) begin
      errors++;
      $display("FAIL sat_hold stall_cnt: got %0d want %0d", stall_cnt_o, {CNT_W{1'b1}});
    end
  endtask

  task automatic test_reset_mid_stall();
    instr_t a;
    a = mk_add(5'd3, 5'd2, 5'd4);
    drive("rm_lw", mk_lw(5'd2, 5'd1), 0, 0);
    @(negedge clk_i);
    apply(a);
    #1;
    checks++;
    if (pc_write_o !== 1'b0) begin
      errors++;
      $display("FAIL rm_stall_before_reset pc_write: got %b want 0", pc_write_o);
    end
    rst_n_i = 0;
    #1;
    checks++;
    if (ex_act !== '0) begin
      errors++;
      $display("FAIL rm_reset ex_regs: got %h want 0", ex_act);
    end
    checks++;
    if (stall_cnt_o !== '0) begin
      errors++;
      $display("FAIL rm_reset stall_cnt: got %0d want 0", stall_cnt_o);
    end
    checks++;
    if (pc_write_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_reset pc_write: got %b want 1", pc_write_o);
    end
    @(negedge clk_i);
    rst_n_i = 1;
    exp_cnt = '0;
    drive("rm_restart", a, 0, 0);
    settle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_zero_reg();
    test_branch_no_hazard();
    test_saturation();
    test_reset_mid_stall();
    settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register combined with the decode-stage hazard unit for the 5-stage MIPS pipeline. Sits directly downstream of the IF/ID register and branch-compare logic. Captures decoded operands and control every cycle and detects load-use and branch-operand hazards. On a hazard it stalls PC and IF/ID and inserts a bubble into EX; it also issues the IF flush for taken branches resolved in ID.

## Interface
Parameters:
- DATA_W, 32, datapath width
- CNT_W, 16, stall-counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- id_rs_addr_i / id_rt_addr_i / id_rd_addr_i  in  5 each  register fields of IF/ID instruction
- id_rs_data_i / id_rt_data_i  in  DATA_W each  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_reg_write_i, id_mem_to_reg_i, id_mem_read_i, id_mem_write_i, id_alu_src_i, id_reg_dst_i  in  1 each  main-control outputs
- id_alu_op_i  in  2  ALU op class
- id_branch_i  in  1  instruction is beq
- id_eq_i  in  1  Equal-unit result for rs/rt data
- pc_write_o  out  1  PC load enable
- if_id_write_o  out  1  IF/ID load enable
- if_flush_o  out  1  clear IF/ID next edge (taken branch)
- branch_taken_o  out  1  select branch target into PC
- ex_reg_write_o, ex_mem_to_reg_o, ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_reg_dst_o  out  1 each  registered control
- ex_alu_op_o  out  2  registered ALU op
- ex_rs_data_o / ex_rt_data_o / ex_imm_o  out  DATA_W each  registered operands
- ex_rs_addr_o / ex_rt_addr_o / ex_rd_addr_o  out  5 each  registered register fields
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- ex_dest = ex_reg_dst_o ? ex_rd_addr_o : ex_rt_addr_o.
- Shadow MEM tracking regs, updated each edge: mem_dest_q <= ex_dest; mem_load_q <= ex_mem_read_o & ex_reg_write_o.
- match(d) = (d != 0) & (d == id_rs_addr_i | d == id_rt_addr_i).
- Load-use hazard: ex_mem_read_o & match(ex_dest).
- Branch-EX hazard: id_branch_i & ex_reg_write_o & match(ex_dest).
- Branch-MEM hazard: id_branch_i & mem_load_q & match(mem_dest_q).
- stall = OR of the three hazards (combinational).
- stall: pc_write_o=0, if_id_write_o=0, branch_taken_o=0, if_flush_o=0; ID/EX loads a bubble (all control and ex_* data/address outputs 0).
- No stall: pc_write_o=1, if_id_write_o=1, ID/EX loads all id_* inputs; branch_taken_o = if_flush_o = id_branch_i & id_eq_i.
- The taken branch itself still enters EX with its own control; beq has reg_write=0, so it creates no hazard.
- stall_cnt_o increments on each edge where stall=1 and saturates at all-ones.
- Register 0 is never a hazard source.

## Timing
- Reset, async on rst_n_i low: all ex_* outputs 0, mem_dest_q=0, mem_load_q=0, stall_cnt_o=0.
  - With these reset values, stall=0, so pc_write_o=1, if_id_write_o=1, and branch_taken_o/if_flush_o follow id_branch_i & id_eq_i.
- Reset released mid-stall: the pipeline restarts from bubbles; no stall persists.
- ID/EX latency is 1 cycle; EX is never stalled, so there is no enable on ID/EX.
- Stall durations:
  - Load-use: 1 cycle.
  - Branch after ALU producer: 1 cycle.
  - Branch after load producer: 2 cycles (Branch-EX, then Branch-MEM on the following cycle).
- Hazard outputs are combinational from current ID fields and registered state. They are valid before the edge that consumes them.
- Simultaneous hazards: the stall lasts as long as any condition holds; each stalled cycle counts once.

## Test plan
- Reset, then lw $2,0($1) followed by add $3,$2,$4 → exactly 1 stall cycle (pc_write_o=0, ex_reg_write_o=0 after that edge); add enters EX on the next edge; stall_cnt_o=1.
- add $5,$6,$7 followed by beq $5,$0 → 1 stall cycle. Next cycle, with id_eq_i=1: branch_taken_o=1, if_flush_o=1.
- lw $8 followed by beq $8,$9 → stalls on 2 consecutive cycles; branch resolves on the 3rd; stall_cnt_o +2.
- lw $0 followed by add $3,$0,$0 → no stall; pc_write_o stays 1.
- beq with no hazard and id_eq_i=0 → branch_taken_o=0, no flush. Same with id_eq_i=1 → flush asserted for exactly 1 cycle.
- Force 2^CNT_W+3 stalls → stall_cnt_o holds all-ones. Assert rst_n_i mid-stall → all ex_* outputs and stall_cnt_o read 0 immediately.
